muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller for the MIPS pipeline: sequences an iterative radix-2 shift-add/shift-subtract datapath for MULT/MULTU/DIV/DIVU and owns the HI/LO registers.
- Sits beside the single-cycle ALU in EX.
- Raises a stall to the hazard unit while an operation is in flight.
- Services MTHI/MTLO writes and MFHI/MFLO reads.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide controller.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Quotient reported for a zero divisor (all ones at 32 bits).
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// shift-subtract for divide. acc holds {upper, lower} halves.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;
    logic [WIDTH:0] diff;

    // Multiply: conditionally add multiplicand into the upper half (with carry).
    assign sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: remainder after the left shift keeps its carry-out bit.
    assign shl  = acc_i[2*WIDTH-1:WIDTH-1];
    assign diff = shl - {1'b0, opnd_i};

    // Select the iteration result; a set diff MSB means the trial subtract went negative.
    always_comb begin
        acc_o = {sum, acc_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            else              acc_o = {shl[WIDTH-1:0],  acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining
// multiplier bits are zero; FIX realigns the accumulator.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;     // product / quotient sign
    logic                 rneg_q, rneg_d;   // remainder sign (dividend sign)
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]     mplier_q, mplier_d;
`endif

    logic                 sgn;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [2*WIDTH-1:0]   step_acc, fix_acc;

    // Operand magnitudes; -2^(WIDTH-1) naturally becomes 2^(WIDTH-1) unsigned.
    assign sgn  = (op == OP_MULT) || (op == OP_DIV);
    assign mag1 = (sgn && in1[WIDTH-1]) ? -in1 : in1;
    assign mag2 = (sgn && in2[WIDTH-1]) ? -in2 : in2;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // cnt_q holds iterations done; skipped iterations are pure right shifts.
    assign fix_acc = is_div_q ? acc_q : (acc_q >> (CNT_W'(WIDTH) - cnt_q));
`else
    assign fix_acc = acc_q;
`endif

    assign busy  = (state_q != S_IDLE);
    assign stall = busy | ((start | hi_we | lo_we) & busy);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Next-state, datapath and HI/LO update; cancel overrides any FIX write.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        mplier_d = mplier_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    is_div_d = op[1];
                    cnt_d    = '0;
                    neg_d    = sgn & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                    rneg_d   = sgn & in1[WIDTH-1];
                    div0_d   = op[1] && (in2 == '0);
                    if (op[1]) begin
                        opnd_d = mag2;
                        acc_d  = {{WIDTH{1'b0}}, mag1};
                    end else begin
                        opnd_d = mag1;
                        acc_d  = {{WIDTH{1'b0}}, mag2};
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    mplier_d = mag2;
`endif
                    if (op[1] && (in2 == '0)) begin
                        acc_d   = {in1, WIDTH'(DIV0_QUOT)};
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                mplier_d = mplier_q >> 1;
                if (!is_div_q && (mplier_d == '0)) state_d = S_FIX;
`endif
            end
            S_FIX: begin
                if (div0_q) begin
                    {hi_d, lo_d} = acc_q;
                end else if (!is_div_q) begin
                    {hi_d, lo_d} = neg_q ? -fix_acc : fix_acc;
                end else begin
                    hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (cancel && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // State and working registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_EARLY_OUT_EN
            mplier_q <= mplier_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl (default build, WIDTH = 32).
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, cancel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in1 = '0, in2 = '0, wdata = '0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int compared = 0;
    int mismatched = 0;

    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {HI, LO} from plain arithmetic on the architectural rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb); return p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa % sb;
                qv = 64'(q); rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op from a negedge, wait (bounded) for done, check latency and result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          n, lat;
        bit          got;
        exp = model(o, a, b);
        lat = (o[1] && b == 0) ? 1 : 33;
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            if (done) got = 1'b1;
            else begin @(posedge clk); @(negedge clk); n++; end
        end
        chk({tag, ".lat"}, 64'(n), 64'(lat));
        chk({tag, ".hilo"}, {hi, lo}, exp);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
        @(posedge clk); @(negedge clk);
        chk({tag, ".pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, h0, l0;

        // reset state
        #12;
        chk("rst", {31'b0, busy, 31'b0, stall, 31'b0, done}, 96'b0);
        chk("rst.hilo", {hi, lo}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
        chk("mult_neg.lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max.lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2.lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.lit", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("divu_0", 2'b11, 32'd100, 32'd0);
        chk("divu_0.lit", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run_op("div_0", 2'b10, 32'hFFFF_FFF0, 32'd0);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op("div_rneg", 2'b10, 32'd7, 32'hFFFF_FFFE);

        // cancel mid-run: HI/LO kept, no done
        h0 = hi; l0 = lo;
        op = 2'b01; in1 = 32'd7; in2 = 32'd9; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        cancel = 1'b1;
        @(posedge clk); @(negedge clk); cancel = 1'b0;
        chk("cancel.busy", 64'(busy), 64'd0);
        chk("cancel.hilo", {hi, lo}, {h0, l0});
        begin
            int dn = 0;
            repeat (40) begin @(posedge clk); @(negedge clk); dn += int'(done); end
            chk("cancel.nodone", 64'(dn), 64'd0);
        end
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); @(negedge clk); hi_we = 1'b0;
        chk("mthi", {hi, lo}, {32'h1234, l0});

        // MTHI in the same cycle as start: write lands, then result overwrites
        op = 2'b01; in1 = 32'd6; in2 = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'hABCD_0000;
        @(posedge clk); @(negedge clk); start = 1'b0; hi_we = 1'b0;
        chk("mthi_start.hi", 64'(hi), 64'hABCD_0000);
        repeat (33) begin @(posedge clk); @(negedge clk); end
        chk("mthi_start.res", {64'(done), hi, lo}, {64'd1, 64'd42});

        // start/lo_we while busy: stall, ignored; then async reset mid-op
        @(negedge clk);
        l0 = lo;
        op = 2'b10; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        start = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; op = 2'b01;
        #1;
        chk("busy_req.stall", 64'(stall), 64'd1);
        @(posedge clk); @(negedge clk); start = 1'b0; lo_we = 1'b0;
        chk("busy_req.lo", 64'(lo), 64'(l0));
        chk("busy_req.busy", 64'(busy), 64'd1);
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        chk("async_rst", {31'b0, busy, 31'b0, stall, 31'b0, done}, 96'b0);
        chk("async_rst.hilo", {hi, lo}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
